// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that time-shares one combinational ALU between two
// valid/ready requesters, returning each result on the winner's response channel.
module alu_share_arbiter #(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [width-1:0] r0_SrcA,
    input  logic [width-1:0] r0_SrcB,
    input  logic [2:0]       r0_ALUControl,
    output logic             r0_rsp_valid,
    input  logic             r0_rsp_ready,
    output logic [width-1:0] r0_result,
    output logic             r0_zero,

    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [width-1:0] r1_SrcA,
    input  logic [width-1:0] r1_SrcB,
    input  logic [2:0]       r1_ALUControl,
    output logic             r1_rsp_valid,
    input  logic             r1_rsp_ready,
    output logic [width-1:0] r1_result,
    output logic             r1_zero,

    output logic [width-1:0] alu_SrcA,
    output logic [width-1:0] alu_SrcB,
    output logic [2:0]       alu_ALUControl,
    input  logic [width-1:0] alu_ALUResult,
    input  logic             alu_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_next;

    // Requester index encoding throughout: 0 = R0, 1 = R1.
    logic             prio;
    logic             gnt;
    logic             pick;
    logic             accept;
    logic             rsp_fire;

    logic [width-1:0] op_a;
    logic [width-1:0] op_b;
    logic [2:0]       op_ctl;

    logic [width-1:0] r0_res_q;
    logic [width-1:0] r1_res_q;
    logic             r0_zero_q;
    logic             r1_zero_q;
    logic             r0_rsp_q;
    logic             r1_rsp_q;

    // Arbitration: a lone requester always wins; a tie goes to prio.
    always_comb begin
        pick     = (r0_valid & r1_valid) ? prio : r1_valid;
        accept   = (state == IDLE) & (r0_valid | r1_valid);
        r0_ready = accept & ~pick;
        r1_ready = accept & pick;
        rsp_fire = (state == RESP) &
                   (gnt ? (r1_rsp_q & r1_rsp_ready) : (r0_rsp_q & r0_rsp_ready));
    end

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept)   state_next = EXEC;
            EXEC:               state_next = RESP;
            RESP: if (rsp_fire) state_next = IDLE;
            default:            state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operand registers feed the shared ALU directly, so its inputs only move on accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a   <= '0;
            op_b   <= '0;
            op_ctl <= '0;
            gnt    <= 1'b0;
        end else if (accept) begin
            op_a   <= pick ? r1_SrcA       : r0_SrcA;
            op_b   <= pick ? r1_SrcB       : r0_SrcB;
            op_ctl <= pick ? r1_ALUControl : r0_ALUControl;
            gnt    <= pick;
        end
    end

    // Per-requester result registers keep one side's result stable while the other runs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r0_res_q  <= '0;
            r1_res_q  <= '0;
            r0_zero_q <= 1'b0;
            r1_zero_q <= 1'b0;
        end else if (state == EXEC) begin
            if (gnt) begin
                r1_res_q  <= alu_ALUResult;
                r1_zero_q <= alu_zero;
            end else begin
                r0_res_q  <= alu_ALUResult;
                r0_zero_q <= alu_zero;
            end
        end
    end

    // Response flags rise entering RESP; prio flips only when a response completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r0_rsp_q <= 1'b0;
            r1_rsp_q <= 1'b0;
            prio     <= 1'b0;
        end else if (state == EXEC) begin
            r0_rsp_q <= ~gnt;
            r1_rsp_q <= gnt;
        end else if (rsp_fire) begin
            r0_rsp_q <= 1'b0;
            r1_rsp_q <= 1'b0;
            prio     <= ~gnt;
        end
    end

    assign alu_SrcA       = op_a;
    assign alu_SrcB       = op_b;
    assign alu_ALUControl = op_ctl;

    assign r0_rsp_valid = r0_rsp_q;
    assign r1_rsp_valid = r1_rsp_q;
    assign r0_result    = r0_res_q;
    assign r1_result    = r1_res_q;
    assign r0_zero      = r0_zero_q;
    assign r1_zero      = r1_zero_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: a table of single-requester operations
// plus hand-written contention, backpressure and mid-operation reset sequences.
module tb_alu_share_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  valid;
    logic [1:0]  ready;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [1:0]  zero;
    logic [31:0] src_a  [2];
    logic [31:0] src_b  [2];
    logic [2:0]  ctl    [2];
    logic [31:0] result [2];

    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_ctl;
    logic [31:0] alu_res;
    logic        alu_z;

    int checks = 0;
    int errors = 0;

    alu_share_arbiter #(.width(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .r0_valid       (valid[0]),
        .r0_ready       (ready[0]),
        .r0_SrcA        (src_a[0]),
        .r0_SrcB        (src_b[0]),
        .r0_ALUControl  (ctl[0]),
        .r0_rsp_valid   (rsp_valid[0]),
        .r0_rsp_ready   (rsp_ready[0]),
        .r0_result      (result[0]),
        .r0_zero        (zero[0]),
        .r1_valid       (valid[1]),
        .r1_ready       (ready[1]),
        .r1_SrcA        (src_a[1]),
        .r1_SrcB        (src_b[1]),
        .r1_ALUControl  (ctl[1]),
        .r1_rsp_valid   (rsp_valid[1]),
        .r1_rsp_ready   (rsp_ready[1]),
        .r1_result      (result[1]),
        .r1_zero        (zero[1]),
        .alu_SrcA       (alu_a),
        .alu_SrcB       (alu_b),
        .alu_ALUControl (alu_ctl),
        .alu_ALUResult  (alu_res),
        .alu_zero       (alu_z)
    );

    // Reference single-cycle ALU standing in for the shared instance.
    always_comb begin
        alu_res = '0;
        case (alu_ctl)
            3'b010:  alu_res = alu_a + alu_b;
            3'b110:  alu_res = alu_a - alu_b;
            3'b000:  alu_res = alu_a & alu_b;
            3'b001:  alu_res = alu_a | alu_b;
            3'b111:  alu_res = {31'd0, alu_a < alu_b};
            default: alu_res = '0;
        endcase
        alu_z = (alu_res == 32'd0);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int          who;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
        logic        exp_zero;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic request(input int who, input logic [2:0] c, input logic [31:0] a,
                           input logic [31:0] b);
        ctl[who]   = c;
        src_a[who] = a;
        src_b[who] = b;
        valid[who] = 1'b1;
    endtask

    // Called just after a falling edge; returns 1 ns after the accepting rising edge.
    task automatic wait_accept(input int who);
        int n = 0;
        #1;
        while (!ready[who] && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check($sformatf("accept_ready_r%0d", who), {31'd0, ready[who]}, 32'd1);
        @(posedge clk);
        #1;
        valid[who] = 1'b0;
    endtask

    // Follows an accept: one EXEC cycle, RESP from T+2, optional stall, then handshake.
    task automatic expect_response(input int who, input logic [31:0] exp_res,
                                   input logic exp_zero, input logic [2:0] exp_ctl,
                                   input int stall);
        int          oth = 1 - who;
        logic [1:0]  exp_v;
        exp_v = (who == 0) ? 2'b01 : 2'b10;
        @(negedge clk);
        check("exec_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        check("exec_ready", {30'd0, ready}, 32'd0);
        check("exec_alu_ctl", {29'd0, alu_ctl}, {29'd0, exp_ctl});
        @(negedge clk);
        check($sformatf("rsp_valid_r%0d", who), {30'd0, rsp_valid}, {30'd0, exp_v});
        check($sformatf("result_r%0d", who), result[who], exp_res);
        check($sformatf("zero_r%0d", who), {31'd0, zero[who]}, {31'd0, exp_zero});
        rsp_ready[oth] = 1'b1;
        repeat (stall) begin
            @(negedge clk);
            check("stall_rsp_valid", {30'd0, rsp_valid}, {30'd0, exp_v});
            check("stall_result", result[who], exp_res);
            check("stall_ready", {30'd0, ready}, 32'd0);
        end
        rsp_ready[oth] = 1'b0;
        rsp_ready[who] = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready[who] = 1'b0;
        check("rsp_drop", {30'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{0, 3'b010, 32'd5,          32'd7,          32'd12,         1'b0};
        vecs[1] = '{1, 3'b110, 32'd3,          32'd5,          32'hFFFF_FFFE,  1'b0};
        vecs[2] = '{0, 3'b000, 32'hF0F0_F0F0,  32'h0FF0_0FF0,  32'h00F0_00F0,  1'b0};
        vecs[3] = '{1, 3'b001, 32'h0000_000F,  32'h0000_00F0,  32'h0000_00FF,  1'b0};
        vecs[4] = '{0, 3'b111, 32'd3,          32'd4,          32'd1,          1'b0};
        vecs[5] = '{1, 3'b111, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1};
        vecs[6] = '{0, 3'b011, 32'd5,          32'd7,          32'd0,          1'b1};
        vecs[7] = '{1, 3'b010, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1};
        vecs[8] = '{0, 3'b110, 32'd9,          32'd9,          32'd0,          1'b1};
        vecs[9] = '{1, 3'b100, 32'd1,          32'd1,          32'd0,          1'b1};

        rst       = 1'b1;
        valid     = 2'b00;
        rsp_ready = 2'b00;
        for (int i = 0; i < 2; i++) begin
            src_a[i] = '0;
            src_b[i] = '0;
            ctl[i]   = '0;
        end

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        check("reset_ready", {30'd0, ready}, 32'd0);
        check("reset_alu_a", alu_a, 32'd0);
        check("reset_alu_ctl", {29'd0, alu_ctl}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("idle_no_valid_ready", {30'd0, ready}, 32'd0);

        // Single-requester operations
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            request(vecs[i].who, vecs[i].op, vecs[i].a, vecs[i].b);
            wait_accept(vecs[i].who);
            check("operand_a_latched", alu_a, vecs[i].a);
            check("operand_b_latched", alu_b, vecs[i].b);
            expect_response(vecs[i].who, vecs[i].exp_res, vecs[i].exp_zero, vecs[i].op, 0);
        end

        // Both valid after reset: R0 first, then R1 in the very next IDLE cycle
        @(negedge clk);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        @(negedge clk);
        request(0, 3'b110, 32'd9, 32'd9);
        request(1, 3'b111, 32'd3, 32'd4);
        #1;
        check("both_grant_r0", {30'd0, ready}, 32'd1);
        wait_accept(0);
        expect_response(0, 32'd0, 1'b1, 3'b110, 0);
        @(negedge clk);
        wait_accept(1);
        expect_response(1, 32'd1, 1'b0, 3'b111, 0);

        // Re-request both: prio is back to R0; then backpressure R0 with R1 waiting
        @(negedge clk);
        request(0, 3'b010, 32'd1, 32'd2);
        request(1, 3'b001, 32'h0F, 32'hF0);
        #1;
        check("prio_back_r0", {30'd0, ready}, 32'd1);
        wait_accept(0);
        expect_response(0, 32'd3, 1'b0, 3'b010, 5);
        @(negedge clk);
        #1;
        check("r1_first_idle", {30'd0, ready}, 32'd2);
        wait_accept(1);

        // Async reset during R1's EXEC cycle
        #1;
        rst = 1'b1;
        #1;
        check("midrst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        check("midrst_ready", {30'd0, ready}, 32'd0);
        check("midrst_alu_a", alu_a, 32'd0);
        check("midrst_alu_b", alu_b, 32'd0);
        check("midrst_alu_ctl", {29'd0, alu_ctl}, 32'd0);
        check("midrst_r0_result", result[0], 32'd0);
        #1;
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check("no_rsp_after_reset", {30'd0, rsp_valid}, 32'd0);
            check("no_ready_without_valid", {30'd0, ready}, 32'd0);
        end
        @(negedge clk);
        request(0, 3'b000, 32'hFF, 32'h0F);
        request(1, 3'b010, 32'd1, 32'd1);
        #1;
        check("prio_after_reset", {30'd0, ready}, 32'd1);
        wait_accept(0);
        expect_response(0, 32'h0F, 1'b0, 3'b000, 0);
        @(negedge clk);
        wait_accept(1);
        expect_response(1, 32'd2, 1'b0, 3'b010, 0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
